// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank, its increment/clear arbiter and the VGA reader.
package reg_bank_pkg;

    localparam int BIT_ADDR_DEF = 4;
    localparam int BIT_DATO_DEF = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WR    = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/reg_bank_arbiter_if.sv
// Requester and bank-port signal bundle of the register bank arbiter.
// slave is the arbiter's view; master is the requester/bank environment's view.
interface reg_bank_arbiter_if import reg_bank_pkg::*; #(
    parameter int BIT_ADDR = BIT_ADDR_DEF,
    parameter int BIT_DATO = BIT_DATO_DEF
) ();

    logic                req_a;
    logic [BIT_ADDR-1:0] addr_a;
    logic                ack_a;
    logic                req_b;
    logic [BIT_ADDR-1:0] addr_b;
    logic                ack_b;
    logic                clr_req;
    logic                clr_done;
    logic                busy;
    logic [BIT_ADDR-1:0] bank_raddr;
    logic [BIT_DATO-1:0] bank_rdata;
    logic                bank_we;
    logic [BIT_ADDR-1:0] bank_waddr;
    logic [BIT_DATO-1:0] bank_wdata;

    modport slave (
        input  req_a, addr_a, req_b, addr_b, clr_req, bank_rdata,
        output ack_a, ack_b, clr_done, busy,
               bank_raddr, bank_we, bank_waddr, bank_wdata
    );

    modport master (
        output req_a, addr_a, req_b, addr_b, clr_req, bank_rdata,
        input  ack_a, ack_b, clr_done, busy,
               bank_raddr, bank_we, bank_waddr, bank_wdata
    );

endinterface

// File: rtl/reg_bank_arbiter_rr.sv
// Two-way round-robin picker: combinational one-hot grant; the favour flips only
// when a contended grant is taken (adv_i high with both requests present).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic fav_b_q;
    logic fav_b_d;

    // gnt_o[0] selects A, gnt_o[1] selects B
    always_comb begin
        gnt_o = 2'b00;
        if (req_a_i && req_b_i) begin
            gnt_o = fav_b_q ? 2'b10 : 2'b01;
        end else if (req_a_i) begin
            gnt_o = 2'b01;
        end else if (req_b_i) begin
            gnt_o = 2'b10;
        end
    end

    always_comb begin
        fav_b_d = fav_b_q;
        if (adv_i && req_a_i && req_b_i) begin
            fav_b_d = ~fav_b_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fav_b_q <= 1'b0;
        end else begin
            fav_b_q <= fav_b_d;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Serialises read-modify-write increments from two requesters and whole-bank clears.
// Increment: ack two cycles after grant; clear: NREG write cycles; requests outside IDLE wait.
module reg_bank_arbiter import reg_bank_pkg::*; #(
    parameter int BIT_ADDR = BIT_ADDR_DEF,
    parameter int BIT_DATO = BIT_DATO_DEF
) (
    input  logic               clk,
    input  logic               rst,
    reg_bank_arbiter_if.slave  bus
);

    localparam logic [BIT_ADDR-1:0] LAST_ADDR = {BIT_ADDR{1'b1}};

    state_t              state_q, state_d;
    req_id_t             id_q, id_d;
    logic [BIT_ADDR-1:0] addr_q, addr_d;
    logic [BIT_ADDR-1:0] cnt_q, cnt_d;
    logic [BIT_DATO-1:0] data_q, data_d;
    logic [1:0]          gnt;
    logic                adv;

    // A pending clear steals the IDLE slot, so the favour must not move then.
    assign adv = (state_q == ST_IDLE) && !bus.clr_req;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_a_i (bus.req_a),
        .req_b_i (bus.req_b),
        .adv_i   (adv),
        .gnt_o   (gnt)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (gnt != 2'b00) begin
                    state_d = ST_RD;
                    id_d    = gnt[1] ? REQ_B : REQ_A;
                    addr_d  = gnt[1] ? bus.addr_b : bus.addr_a;
                end
            end
            ST_RD: begin
                data_d  = bus.bank_rdata;
                state_d = ST_WR;
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode from registered state only, so reset clears them without a clock.
    always_comb begin
        bus.busy       = (state_q != ST_IDLE);
        bus.bank_raddr = '0;
        bus.bank_we    = 1'b0;
        bus.bank_waddr = '0;
        bus.bank_wdata = '0;
        bus.ack_a      = 1'b0;
        bus.ack_b      = 1'b0;
        bus.clr_done   = 1'b0;
        case (state_q)
            ST_RD: begin
                bus.bank_raddr = addr_q;
            end
            ST_WR: begin
                bus.bank_we    = 1'b1;
                bus.bank_waddr = addr_q;
                bus.bank_wdata = data_q + 1'b1;
                bus.ack_a      = (id_q == REQ_A);
                bus.ack_b      = (id_q == REQ_B);
            end
            ST_CLEAR: begin
                bus.bank_we    = 1'b1;
                bus.bank_waddr = cnt_q;
                bus.clr_done   = (cnt_q == LAST_ADDR);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            id_q    <= REQ_A;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Bench for reg_bank_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of expected bank-port activity.
module tb_reg_bank_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 3;
    localparam int NREG = 16;

    typedef struct packed {
        logic          busy;
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic [AW-1:0] raddr;
        logic          ack_a;
        logic          ack_b;
        logic          clr_done;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_bank_arbiter_if #(.BIT_ADDR(AW), .BIT_DATO(DW)) bus ();

    reg_bank_arbiter #(.BIT_ADDR(AW), .BIT_DATO(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Bank memory seen by the arbiter, with a side door for presetting entries.
    logic [DW-1:0] bank [NREG];
    logic          pl_vld;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_val;

    always @(posedge clk) begin
        if (bus.bank_we) begin
            bank[bus.bank_waddr] <= bus.bank_wdata;
        end else if (pl_vld) begin
            bank[pl_addr] <= pl_val;
        end
    end
    assign bus.bank_rdata = bank[bus.bank_raddr];

    // Reference model: expected per-cycle activity queued per transaction.
    obs_t          exp_q [$];
    logic [DW-1:0] ref_bank [NREG];
    logic          fav_b;
    int            n_cmp;
    int            n_bad;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.busy     = bus.busy;
        o.we       = bus.bank_we;
        o.waddr    = bus.bank_waddr;
        o.wdata    = bus.bank_wdata;
        o.raddr    = bus.bank_raddr;
        o.ack_a    = bus.ack_a;
        o.ack_b    = bus.ack_b;
        o.clr_done = bus.clr_done;
        return o;
    endfunction

    task automatic set_in(input logic ra, input logic [AW-1:0] aa,
                          input logic rb, input logic [AW-1:0] ab, input logic clr);
        bus.req_a   = ra;
        bus.addr_a  = aa;
        bus.req_b   = rb;
        bus.addr_b  = ab;
        bus.clr_req = clr;
    endtask

    // Called in a cycle where the arbiter should be idle: decide what it starts.
    task automatic model_decide();
        obs_t          e;
        logic          win_b;
        logic [AW-1:0] a;
        if (bus.clr_req) begin
            for (int i = 0; i < NREG; i++) begin
                e          = '0;
                e.busy     = 1'b1;
                e.we       = 1'b1;
                e.waddr    = AW'(i);
                e.clr_done = (i == NREG - 1);
                exp_q.push_back(e);
                ref_bank[i] = '0;
            end
        end else if (bus.req_a || bus.req_b) begin
            win_b = (bus.req_a && bus.req_b) ? fav_b : !bus.req_a;
            if (bus.req_a && bus.req_b) begin
                fav_b = !fav_b;
            end
            a           = win_b ? bus.addr_b : bus.addr_a;
            ref_bank[a] = ref_bank[a] + 1'b1;
            e           = '0;
            e.busy      = 1'b1;
            e.raddr     = a;
            exp_q.push_back(e);
            e           = '0;
            e.busy      = 1'b1;
            e.we        = 1'b1;
            e.waddr     = a;
            e.wdata     = ref_bank[a];
            e.ack_a     = !win_b;
            e.ack_b     = win_b;
            exp_q.push_back(e);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance model, land just after the edge.
    task automatic step();
        obs_t e;
        logic idle;
        @(negedge clk);
        idle = (exp_q.size() == 0);
        e    = '0;
        if (!idle) begin
            e = exp_q.pop_front();
        end
        chk("cycle", 32'(sample()), 32'(e));
        if (idle) begin
            model_decide();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_outputs", 32'(sample()), 32'd0);
        exp_q.delete();
        fav_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pl_vld      = 1'b1;
        pl_addr     = a;
        pl_val      = v;
        ref_bank[a] = v;
        step();
        pl_vld      = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        pl_vld  = 1'b0;
        pl_addr = '0;
        pl_val  = '0;
        fav_b   = 1'b0;

        do_reset();

        // Clear wins over a simultaneous increment; A is serviced afterwards.
        set_in(1'b1, 4'd4, 1'b0, 4'd0, 1'b1);
        step();
        bus.clr_req = 1'b0;
        repeat (NREG) step();
        step();
        bus.req_a = 1'b0;
        repeat (2) step();
        chk("clr_then_a_bank4", 32'(bank[4]), 32'd1);

        // Contention straight after reset: A first, B three cycles later.
        do_reset();
        set_in(1'b1, 4'd1, 1'b1, 4'd2, 1'b0);
        repeat (3) step();
        bus.req_a = 1'b0;
        repeat (3) step();
        bus.req_b = 1'b0;
        chk("contend_bank1", 32'(bank[1]), 32'd1);
        chk("contend_bank2", 32'(bank[2]), 32'd1);

        // Same target from both sides: favour now with B, no lost update.
        preload(4'd3, 3'd2);
        set_in(1'b1, 4'd3, 1'b1, 4'd3, 1'b0);
        repeat (3) step();
        bus.req_b = 1'b0;
        repeat (3) step();
        bus.req_a = 1'b0;
        chk("same_target_bank3", 32'(bank[3]), 32'd4);

        // Increment wraps 7 -> 0.
        preload(4'd5, 3'd7);
        set_in(1'b1, 4'd5, 1'b0, 4'd0, 1'b0);
        step();
        bus.req_a = 1'b0;
        repeat (2) step();
        chk("wrap_bank5", 32'(bank[5]), 32'd0);

        // Reset in the WR cycle aborts without writing.
        set_in(1'b1, 4'd6, 1'b0, 4'd0, 1'b0);
        step();
        bus.req_a = 1'b0;
        step();
        chk("wr_before_rst", {31'd0, bus.bank_we}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_in_wr", 32'(sample()), 32'd0);
        exp_q.delete();
        fav_b       = 1'b0;
        ref_bank[6] = ref_bank[6] - 1'b1;
        @(posedge clk);
        #1;
        chk("rst_no_write_bank6", 32'(bank[6]), 32'(ref_bank[6]));
        rst = 1'b1;
        set_in(1'b1, 4'd7, 1'b1, 4'd8, 1'b0);
        repeat (3) step();
        bus.req_a = 1'b0;
        repeat (3) step();
        bus.req_b = 1'b0;

        // Random traffic, including requests dropped or changed mid-transaction.
        for (int c = 0; c < 3000; c++) begin
            bus.req_a   = 1'($urandom_range(0, 1));
            bus.addr_a  = AW'($urandom_range(0, NREG - 1));
            bus.req_b   = 1'($urandom_range(0, 1));
            bus.addr_b  = AW'($urandom_range(0, NREG - 1));
            bus.clr_req = ($urandom_range(0, 49) == 0);
            step();
        end

        set_in(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
        for (int c = 0; c < NREG + 4 && exp_q.size() > 0; c++) begin
            step();
        end
        chk("drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < NREG; i++) begin
            chk($sformatf("bank[%0d]", i), 32'(bank[i]), 32'(ref_bank[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 SHALL have parameter BIT_ADDR, default 4, bank address width (NREG = 2**BIT_ADDR entries).
REQ-002 SHALL have parameter BIT_DATO, default 3, bank entry width.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports req_a  input  1  increment request A; addr_a  input  BIT_ADDR  target of A; ack_a  output  1  one-cycle completion of A.
REQ-006 SHALL have ports req_b  input  1  increment request B; addr_b  input  BIT_ADDR  target of B; ack_b  output  1  one-cycle completion of B.
REQ-007 SHALL have ports clr_req  input  1  request to zero the whole bank; clr_done  output  1  one-cycle clear completion.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have bank-side ports bank_raddr  output  BIT_ADDR; bank_rdata  input  BIT_DATO (combinational read data); bank_we  output  1; bank_waddr  output  BIT_ADDR; bank_wdata  output  BIT_DATO.

Function
REQ-010 SHALL implement states IDLE, RD, WR and CLEAR.
REQ-011 In IDLE: clr_req high -> CLEAR (clear has priority over increments); else any req high -> RD, latching the winner's id and address; else stay IDLE.
REQ-012 RD SHALL drive bank_raddr = latched address and capture bank_rdata into a data register at the clock edge ending RD; next state WR.
REQ-013 WR SHALL assert bank_we for exactly one cycle with bank_waddr = latched address and bank_wdata = captured value + 1 modulo 2**BIT_DATO (wraps 7 -> 0 at BIT_DATO=3); the winner's ack is high in that same cycle; next state IDLE.
REQ-014 Increment latency SHALL be: grant edge in IDLE, ack in the 2nd cycle after it; minimum spacing between two increments is 3 cycles.
REQ-015 Arbitration SHALL be two-way round-robin: a single requester is always granted; with both requesting, the favoured requester is granted and the favour then passes to the other.
REQ-016 A granted transaction SHALL complete and ack even if its req drops before ack; a req still high in the IDLE cycle after its ack is a new request.
REQ-017 Requests and address changes arriving outside IDLE SHALL be ignored until the next IDLE cycle; addresses are sampled only at grant.
REQ-018 CLEAR SHALL write bank_wdata = 0 with bank_we = 1 to addresses 0, 1, ..., NREG-1 on consecutive cycles (NREG cycles), pulse clr_done in the cycle writing NREG-1, then return to IDLE.
REQ-019 clr_req and increment requests seen during CLEAR SHALL be ignored; a clr_req still high at the return to IDLE starts another clear.
REQ-020 bank_we SHALL be low in IDLE and RD; ack_a, ack_b and clr_done SHALL never be high simultaneously.

Reset
REQ-021 rst low SHALL immediately force state IDLE, favour to A, clear counter 0, data register 0, and all outputs (ack_a, ack_b, clr_done, busy, bank_we, bank_raddr, bank_waddr, bank_wdata) to 0.
REQ-022 Reset asserted mid-RD, mid-WR or mid-CLEAR SHALL abort the operation with no further bank write and no ack/clr_done; bank contents already written are not restored.
REQ-023 After rst rises, the first grant or clear SHALL occur no earlier than the first rising clk edge.

Structure
REQ-024 BIT_ADDR/BIT_DATO defaults and the state encoding SHALL live in the shared package reg_bank_pkg, used also by the register bank and VGA modules.
REQ-025 Round-robin selection SHALL be a sub-module rr_arbiter2 (inputs two requests plus an advance strobe, outputs a one-hot grant, holds the favour flag).

Verification
REQ-026 Wrap: bank[5]=7, req_a=1 addr_a=5 -> bank_we with waddr 5, wdata 0 and ack_a high 2 cycles after grant.
REQ-027 Contention after reset: req_a (addr 1) and req_b (addr 2) raised together and held until their acks -> ack_a first, ack_b 3 cycles later; bank[1] and bank[2] each +1.
REQ-028 Same target: bank[3]=2, req_a and req_b both addr 3 held until their acks -> two sequential increments, bank[3]=4, no lost update.
REQ-029 Clear priority: clr_req and req_a (addr 4) raised together -> 16 zero writes to 0..15, clr_done with waddr 15, then A serviced: bank[4]=1.
REQ-030 Reset during WR: rst low in the WR cycle -> bank_we, ack and busy go 0 without waiting for a clk edge; after release, state IDLE, favour A.
